pipeline_hazard_ctrl: RTL and testbench

Central stall/flush generator for the 16-bit four-register TSC pipeline. It drives the `stall`/`flush` inputs of the IF/ID, ID/EX, EX/MEM and MEM/WB registers and the PC write enable. Its inputs are:
- stage-tagged fields read back from those registers;
- the instruction- and data-memory ready handshakes.

It tracks memory waits and halt in a small state machine. An optional performance-counter bank can be compiled in.

---
 rtl/pipeline_hazard_ctrl.sv | 152 +++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush/PC-enable generator for the four-register TSC pipeline with a RUN/IWAIT/DWAIT/HALT tracker.
// Define PIPE_PERF_CNT_EN to add saturating cycle/stall/flush performance counters.
module pipeline_hazard_ctrl #(
    parameter int unsigned CNT_W = 16
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] rs_ID,
    input  logic [1:0] rt_ID,
    input  logic       use_rs_ID,
    input  logic       use_rt_ID,
    input  logic       d_readM_EX,
    input  logic       RegWrite_EX,
    input  logic [1:0] write_reg_addr_EX,
    input  logic       d_readM_MEM,
    input  logic       d_writeM_MEM,
    input  logic       mispredict_EX,
    input  logic       jump_ID,
    input  logic       i_mem_ready,
    input  logic       d_mem_ready,
    input  logic       is_halted_WB,
    output logic       pc_write,
    output logic       stall_IF_ID,
    output logic       stall_ID_EX,
    output logic       stall_EX_MEM,
    output logic       stall_MEM_WB,
    output logic       flush_IF_ID,
    output logic       flush_ID_EX,
    output logic       flush_EX_MEM,
    output logic       flush_MEM_WB,
    output logic       halted,
    output logic [1:0] ctrl_state
`ifdef PIPE_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] cyc_cnt,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
`endif
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_IWAIT = 2'd1,
        ST_DWAIT = 2'd2,
        ST_HALT  = 2'd3
    } state_t;

    state_t state_q;
    logic   halted_q;

    logic load_use;
    logic dwait;
    logic iwait;

    assign load_use = d_readM_EX & RegWrite_EX &
                      ((use_rs_ID & (rs_ID == write_reg_addr_EX)) |
                       (use_rt_ID & (rt_ID == write_reg_addr_EX)));
    assign dwait    = (d_readM_MEM | d_writeM_MEM) & ~d_mem_ready;
    assign iwait    = ~i_mem_ready;

    // Priority chain; each row only ever stalls or flushes a given register, never both.
    always_comb begin
        pc_write     = 1'b0;
        stall_IF_ID  = 1'b0;
        stall_ID_EX  = 1'b0;
        stall_EX_MEM = 1'b0;
        stall_MEM_WB = 1'b0;
        flush_IF_ID  = 1'b0;
        flush_ID_EX  = 1'b0;
        flush_EX_MEM = 1'b0;
        flush_MEM_WB = 1'b0;
        if (!reset_n) begin
            flush_IF_ID  = 1'b1;
            flush_ID_EX  = 1'b1;
            flush_EX_MEM = 1'b1;
            flush_MEM_WB = 1'b1;
        end else if (state_q == ST_HALT) begin
            stall_IF_ID  = 1'b1;
            stall_ID_EX  = 1'b1;
            stall_EX_MEM = 1'b1;
            stall_MEM_WB = 1'b1;
        end else if (dwait) begin
            stall_IF_ID  = 1'b1;
            stall_ID_EX  = 1'b1;
            stall_EX_MEM = 1'b1;
            flush_MEM_WB = 1'b1;
        end else if (mispredict_EX) begin
            pc_write    = 1'b1;
            flush_IF_ID = 1'b1;
            flush_ID_EX = 1'b1;
        end else if (load_use) begin
            stall_IF_ID = 1'b1;
            flush_ID_EX = 1'b1;
        end else if (iwait) begin
            flush_IF_ID = 1'b1;
        end else if (jump_ID) begin
            pc_write    = 1'b1;
            flush_IF_ID = 1'b1;
        end else begin
            pc_write = 1'b1;
        end
    end

    // HALT is absorbing; only reset returns to RUN.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= ST_RUN;
            halted_q <= 1'b0;
        end else if (state_q != ST_HALT) begin
            if (is_halted_WB) begin
                state_q  <= ST_HALT;
                halted_q <= 1'b1;
            end else if (dwait) begin
                state_q <= ST_DWAIT;
            end else if (iwait && !mispredict_EX && !load_use) begin
                state_q <= ST_IWAIT;
            end else begin
                state_q <= ST_RUN;
            end
        end
    end

    assign ctrl_state = state_q;
    assign halted     = halted_q;

`ifdef PIPE_PERF_CNT_EN
    logic [2:0]         cnt_inc;
    logic [3*CNT_W-1:0] cnt_bus;

    // Only a redirect (mispredict or jump) pairs pc_write with an IF/ID flush.
    assign cnt_inc = {pc_write & flush_IF_ID, ~pc_write, 1'b1};

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : gen_cnt
            logic [CNT_W-1:0] cnt_q;
            always_ff @(posedge clk) begin
                if (!reset_n) begin
                    cnt_q <= '0;
                end else if ((state_q != ST_HALT) && cnt_inc[gi] && (cnt_q != {CNT_W{1'b1}})) begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end
            assign cnt_bus[gi*CNT_W +: CNT_W] = cnt_q;
        end
    endgenerate

    assign cyc_cnt   = cnt_bus[0*CNT_W +: CNT_W];
    assign stall_cnt = cnt_bus[1*CNT_W +: CNT_W];
    assign flush_cnt = cnt_bus[2*CNT_W +: CNT_W];
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Randomized bench for pipeline_hazard_ctrl against a rule-level reference model.
// Define PIPE_PERF_CNT_EN to also check the counters (built with CNT_W=4).
module tb_pipeline_hazard_ctrl;
    localparam int CNT_W = 4;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [1:0] rs_ID, rt_ID, write_reg_addr_EX;
    logic       use_rs_ID, use_rt_ID, d_readM_EX, RegWrite_EX;
    logic       d_readM_MEM, d_writeM_MEM, mispredict_EX, jump_ID;
    logic       i_mem_ready, d_mem_ready, is_halted_WB;
    logic       pc_write, halted;
    logic       stall_IF_ID, stall_ID_EX, stall_EX_MEM, stall_MEM_WB;
    logic       flush_IF_ID, flush_ID_EX, flush_EX_MEM, flush_MEM_WB;
    logic [1:0] ctrl_state;
`ifdef PIPE_PERF_CNT_EN
    logic [CNT_W-1:0] cyc_cnt, stall_cnt, flush_cnt;
`endif

    pipeline_hazard_ctrl #(.CNT_W(CNT_W)) dut (
        .clk(clk), .reset_n(reset_n),
        .rs_ID(rs_ID), .rt_ID(rt_ID), .use_rs_ID(use_rs_ID), .use_rt_ID(use_rt_ID),
        .d_readM_EX(d_readM_EX), .RegWrite_EX(RegWrite_EX), .write_reg_addr_EX(write_reg_addr_EX),
        .d_readM_MEM(d_readM_MEM), .d_writeM_MEM(d_writeM_MEM),
        .mispredict_EX(mispredict_EX), .jump_ID(jump_ID),
        .i_mem_ready(i_mem_ready), .d_mem_ready(d_mem_ready), .is_halted_WB(is_halted_WB),
        .pc_write(pc_write),
        .stall_IF_ID(stall_IF_ID), .stall_ID_EX(stall_ID_EX),
        .stall_EX_MEM(stall_EX_MEM), .stall_MEM_WB(stall_MEM_WB),
        .flush_IF_ID(flush_IF_ID), .flush_ID_EX(flush_ID_EX),
        .flush_EX_MEM(flush_EX_MEM), .flush_MEM_WB(flush_MEM_WB),
        .halted(halted), .ctrl_state(ctrl_state)
`ifdef PIPE_PERF_CNT_EN
        , .cyc_cnt(cyc_cnt), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
    );

    always #5 clk = ~clk;

    int err_cnt = 0;
    int chk_cnt = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        chk_cnt++;
        if (obs !== exp_v) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp_v, $time);
        end
    endtask

    // Reference model: 0 RUN, 1 IWAIT, 2 DWAIT, 3 HALT
    int m_state;
    int m_cyc, m_stall, m_flush;
    bit m_redirect;

    function automatic bit m_load_use();
        return d_readM_EX && RegWrite_EX &&
               ((use_rs_ID && rs_ID == write_reg_addr_EX) || (use_rt_ID && rt_ID == write_reg_addr_EX));
    endfunction

    function automatic bit m_dwait();
        return (d_readM_MEM || d_writeM_MEM) && !d_mem_ready;
    endfunction

    // Packed as {pc_write, stalls IF/ID..MEM/WB, flushes IF/ID..MEM/WB}.
    function automatic logic [8:0] m_outputs();
        if (!reset_n)              return 9'b0_0000_1111;
        if (m_state == 3)          return 9'b0_1111_0000;
        if (m_dwait())             return 9'b0_1110_0001;
        if (mispredict_EX)         return 9'b1_0000_1100;
        if (m_load_use())          return 9'b0_1000_0100;
        if (!i_mem_ready)          return 9'b0_0000_1000;
        if (jump_ID)               return 9'b1_0000_1000;
        return 9'b1_0000_0000;
    endfunction

    function automatic int sat_inc(input int v);
        return (v >= (1 << CNT_W) - 1) ? v : v + 1;
    endfunction

    task automatic randomize_inputs();
        reset_n           = ($urandom_range(0, 59) != 0);
        if (m_state == 3 && $urandom_range(0, 5) == 0) reset_n = 1'b0;
        rs_ID             = 2'($urandom_range(0, 3));
        rt_ID             = 2'($urandom_range(0, 3));
        write_reg_addr_EX = 2'($urandom_range(0, 3));
        use_rs_ID         = 1'($urandom_range(0, 1));
        use_rt_ID         = 1'($urandom_range(0, 1));
        d_readM_EX        = ($urandom_range(0, 2) == 0);
        RegWrite_EX       = ($urandom_range(0, 3) != 0);
        d_readM_MEM       = ($urandom_range(0, 2) == 0);
        d_writeM_MEM      = ($urandom_range(0, 5) == 0);
        mispredict_EX     = ($urandom_range(0, 5) == 0);
        jump_ID           = ($urandom_range(0, 4) == 0);
        i_mem_ready       = ($urandom_range(0, 4) != 0);
        d_mem_ready       = ($urandom_range(0, 2) != 0);
        is_halted_WB      = ($urandom_range(0, 69) == 0);
    endtask

    // Advances the model across one posedge using the inputs held during that cycle.
    task automatic model_step();
        logic [8:0] o;
        o = m_outputs();
        m_redirect = o[8] && o[3];
        if (!reset_n) begin
            m_state = 0; m_cyc = 0; m_stall = 0; m_flush = 0;
        end else if (m_state != 3) begin
            m_cyc = sat_inc(m_cyc);
            if (!o[8])      m_stall = sat_inc(m_stall);
            if (m_redirect) m_flush = sat_inc(m_flush);
            if (is_halted_WB)                                          m_state = 3;
            else if (m_dwait())                                        m_state = 2;
            else if (!i_mem_ready && !mispredict_EX && !m_load_use())  m_state = 1;
            else                                                       m_state = 0;
        end
    endtask

    task automatic check_all();
        check_val("outputs", {pc_write, stall_IF_ID, stall_ID_EX, stall_EX_MEM, stall_MEM_WB,
                              flush_IF_ID, flush_ID_EX, flush_EX_MEM, flush_MEM_WB}, m_outputs());
        check_val("ctrl_state", ctrl_state, m_state);
        check_val("halted", halted, (m_state == 3));
`ifdef PIPE_PERF_CNT_EN
        check_val("cyc_cnt", cyc_cnt, m_cyc);
        check_val("stall_cnt", stall_cnt, m_stall);
        check_val("flush_cnt", flush_cnt, m_flush);
`endif
    endtask

    initial begin
        m_state = 0; m_cyc = 0; m_stall = 0; m_flush = 0; m_redirect = 0;
        randomize_inputs();
        reset_n = 1'b0;
        #1;
        check_val("reset_outputs", {pc_write, stall_IF_ID, stall_ID_EX, stall_EX_MEM, stall_MEM_WB,
                                    flush_IF_ID, flush_ID_EX, flush_EX_MEM, flush_MEM_WB}, 9'b0_0000_1111);
        @(posedge clk);
        model_step();
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            randomize_inputs();
            #1;
            check_all();
            @(posedge clk);
            model_step();
        end
        @(negedge clk);
        #1;
        check_all();
        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
